// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: command opcodes and FSM states shared by the burst master.
package mem_burst_pkg;
  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_FILL  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/mem_burst_master_rd_stage.sv
// mem_rd_stage: single-entry registered read-data slot with valid/ready handshake.
module mem_rd_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_i,
  input  logic [N-1:0] data_i,
  input  logic         last_i,
  input  logic         ready_i,
  output logic         free_o,
  output logic         valid_o,
  output logic [N-1:0] data_o,
  output logic         last_o
);
  logic valid_q, valid_d, last_q, last_d;
  logic [N-1:0] data_q, data_d;
  // A capture may coincide with the consumer taking the current word.
  assign free_o = !valid_q || ready_i;
  always_comb begin
    valid_d = cap_i ? 1'b1 : valid_q && !ready_i;
    last_d = cap_i ? last_i : last_q && !ready_i;
    data_d = cap_i ? data_i : data_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  assign valid_o = valid_q;
  assign data_o = data_q;
  assign last_o = last_q;
endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master: SRAM initiator executing single writes, range fills and
// backpressured read bursts, one command at a time.
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 1024,
  parameter int A = $clog2(D)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [A-1:0] cmd_addr,
  input  logic [A:0]   cmd_len,
  input  logic [N-1:0] cmd_data,
  output logic         mem_wren,
  output logic [A-1:0] mem_waddr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_rden,
  output logic [A-1:0] mem_raddr,
  input  logic [N-1:0] mem_rdata,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [N-1:0] rd_data,
  output logic         rd_last,
  output logic         busy,
  output logic         done,
  output logic         err
);
  state_e state_q;
  logic [A:0] cnt_q;
  logic [A-1:0] waddr_q, raddr_q;
  logic [N-1:0] wdata_q;
  logic wren_q, err_q, free, cap, last;
  assign cmd_ready = state_q == ST_IDLE;
  assign busy = !cmd_ready;
  assign done = state_q == ST_DONE;
  assign err = err_q;
  assign mem_wren = wren_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_raddr = raddr_q;
  assign cap = state_q == ST_READ && free;
  assign mem_rden = cap;
  assign last = cnt_q == (A+1)'(1);
  mem_rd_stage #(.N(N)) u_rd (
    .clk(clk),
    .rst(rst),
    .cap_i(cap),
    .data_i(mem_rdata),
    .last_i(last),
    .ready_i(rd_ready),
    .free_o(free),
    .valid_o(rd_valid),
    .data_o(rd_data),
    .last_o(rd_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      wren_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          cnt_q <= cmd_len;
          err_q <= cmd_op == OP_RSVD;
          if (cmd_op == OP_WRITE || (cmd_op == OP_FILL && cmd_len != '0)) begin
            waddr_q <= cmd_addr;
            wdata_q <= cmd_data;
            wren_q <= 1'b1;
            state_q <= cmd_op == OP_WRITE ? ST_WRITE : ST_FILL;
          end else if (cmd_op == OP_READ && cmd_len != '0) begin
            raddr_q <= cmd_addr;
            state_q <= ST_READ;
          end else state_q <= ST_DONE;
        end
        ST_WRITE: begin
          wren_q <= 1'b0;
          state_q <= ST_DONE;
        end
        ST_FILL: if (last) begin
          wren_q <= 1'b0;
          state_q <= ST_DONE;
        end else begin
          waddr_q <= waddr_q + A'(1);
          cnt_q <= cnt_q - (A+1)'(1);
        end
        // Addresses stop on the final word so the pins hold their last value.
        ST_READ: if (cap) begin
          if (last) state_q <= ST_DRAIN;
          else begin
            raddr_q <= raddr_q + A'(1);
            cnt_q <= cnt_q - (A+1)'(1);
          end
        end
        ST_DRAIN: if (rd_valid && rd_ready) state_q <= ST_DONE;
        ST_DONE: begin
          err_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator for the team's single-port-pair synchronous SRAM (write port + combinational read port).
- Accepts one command at a time over a valid/ready interface: single WRITE, FILL of an address range, or READ burst of a range.
- Drives the SRAM wren/waddr/wdata/rden/raddr pins and returns read data as a backpressured stream.
- Sits between control/DMA logic and the SRAM instance; used for memory init, scrub and bulk readout.

Parameters:
- N, 32: data width in bits; must match the SRAM.
- D, 1024: SRAM depth; power of two.
- A, $clog2(D): address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  command: 0 WRITE, 1 READ, 2 FILL, 3 reserved.
- cmd_addr  in  A  start address.
- cmd_len  in  A+1  word count, 0..D; ignored for WRITE, which is always 1.
- cmd_data  in  N  write data (WRITE) or fill value (FILL).
- mem_wren  out  1  SRAM write enable.
- mem_waddr  out  A  SRAM write address.
- mem_wdata  out  N  SRAM write data.
- mem_rden  out  1  SRAM read enable.
- mem_raddr  out  A  SRAM read address.
- mem_rdata  in  N  SRAM read data; combinational from raddr, same cycle.
- rd_valid  out  1  read stream valid.
- rd_ready  in  1  read stream ready.
- rd_data  out  N  read word; registered.
- rd_last  out  1  final word of burst; qualified by rd_valid.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse, coincident with done, for op 3.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except cmd_ready=1. Addresses/data outputs 0.
- Reset during a command aborts it immediately. No further SRAM writes. Stream is dropped with no rd_last.
- cmd_ready = (state==IDLE). Command fields are latched on the accept edge; inputs may change afterwards.
- The FSM is registered. No combinational path from cmd_* to any mem_* output.
- States: IDLE, WRITE, FILL, READ, DRAIN, DONE.
- Addressing: address = (start + index) mod D. Wrap-around past D-1 to 0 is legal.
- Remaining-count counter is A+1 bits.
- IDLE -> WRITE: on accept with op 0.
- WRITE: mem_wren=1, waddr=addr, wdata=data for exactly one cycle, then -> DONE.
- IDLE -> FILL: on accept with op 2 and len>0.
- FILL: mem_wren=1 every cycle for len consecutive cycles at successive addresses, wdata=fill value. After the last write -> DONE.
- Accepted at cycle 0, writes occur in cycles 1..len, done in cycle len+1.
- IDLE -> READ: on accept with op 1 and len>0.
- READ: in any cycle where (!rd_valid || rd_ready), assert mem_rden with mem_raddr=current address. Capture mem_rdata into rd_data, set rd_valid, set rd_last if it is the final word, then advance.
- READ otherwise: hold mem_rden=0 and hold rd_data/rd_valid stable. Word order and content are never lost or duplicated under backpressure.
- READ -> DRAIN after capturing the final word. DRAIN -> DONE on rd_valid && rd_ready, which clears rd_valid and rd_last.
- With rd_ready held 1: rden in cycles 1..len, rd_valid in cycles 2..len+1, done in cycle len+2.
- len==0 (READ/FILL) or op 3: -> DONE directly with no SRAM access and no stream output. err=1 for op 3 only.
- DONE: done=1 for one cycle, then -> IDLE. cmd_ready returns the cycle after done.
- mem_wren and mem_rden are never asserted together. Outside active cycles they are 0. mem_waddr/mem_raddr hold their last value.

Decomposition:
- Package mem_burst_pkg:
  - op enum (OP_WRITE=2'd0, OP_READ=2'd1, OP_FILL=2'd2, OP_RSVD=2'd3).
  - FSM state enum.
- One natural sub-module, mem_rd_stage: a single-entry registered output with valid/ready. It handles capture-enable, rd_valid/rd_last hold and clear.
- The FSM and address/count generation stay in the top.

Test Plan:
- Reset then WRITE addr=5 data=32'hDEADBEEF -> mem_wren one cycle with waddr=5, wdata=DEADBEEF. done at cycle 2, err=0. cmd_ready low cycles 1..2.
- FILL addr=1020 len=8 data=32'hA5A5A5A5 (D=1024) -> 8 consecutive writes at 1020..1023,0..3. done at cycle 9. SRAM model matches.
- READ addr=0 len=4 with rd_ready=1 after FILL -> rd_data sequence equals contents of 0..3 in cycles 2..5. rd_last only in cycle 5. done in cycle 6.
- READ len=6 with rd_ready toggling 1,0,0,1,0,1... -> rd_data stable while stalled. Exactly 6 handshakes in address order. rden only when slot free.
- READ len=0 and op=3 -> no mem_wren/mem_rden. done next cycle. err=1 only for op 3.
- Assert rst in cycle 3 of FILL len=16 -> writes stop the same cycle. Outputs reset. cmd_ready=1 after release, and a new WRITE completes normally.
